// File: rtl/regfile_arb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
// Shared types and default constants for the two-master register-file
// arbiter (regfile_arbiter) and its winner-selection sub-block (rr_arbiter2).
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths (16 / 3)
//   state_t                 : sequencer states IDLE, ISSUE, WAIT, DONE
//   gnt_t                   : grant index, 0 = master 0, 1 = master 1
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic gnt_t;

    // The master that did not win; round-robin hands priority to it.
    function automatic gnt_t other_master(input gnt_t g);
        return ~g;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way winner selection for regfile_arbiter. The selection is purely
// combinational; the only state is the one-bit priority pointer.
// Build option: REGFILE_ARB_FIXED_PRIO_EN
//   undefined (default) : round-robin, the pointer's master wins a tie and the
//                         pointer moves to the loser after every grant
//   defined             : fixed priority, master 0 wins any tie, no pointer
// Ports:
//   CLK, RST   clock and synchronous active-high reset (pointer -> master 0)
//   req0/req1  requests currently presented
//   advance    a grant is being taken this cycle; moves the pointer
//   gnt_valid  at least one request present
//   gnt_idx    index of the winning master
// -----------------------------------------------------------------------------
module rr_arbiter2
    import regfile_arb_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic gnt_valid,
    output gnt_t gnt_idx
);

`ifdef REGFILE_ARB_FIXED_PRIO_EN

    // No state in this variant; the clock, reset and advance inputs stay on the
    // port list so both builds share one instantiation.
    logic unused_ok;
    assign unused_ok = &{1'b0, CLK, RST, advance};

    always_comb begin
        gnt_valid = req0 | req1;
        gnt_idx   = req0 ? 1'b0 : 1'b1;
    end

`else

    gnt_t ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= other_master(gnt_idx);
        end
    end

    // NOTE: each output is assigned a default at the top of the block, so no
    // path through the if/else leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_idx   = 1'b0;
        if (req0 && req1) begin
            gnt_idx = ptr;
        end else if (req1) begin
            gnt_idx = 1'b1;
        end
    end

`endif

endmodule

// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
// Arbitrates read/write transactions from two masters onto the single port of
// an 8 x 16 register file. One transaction at a time: IDLE picks a winner and
// latches its payload, ISSUE pulses exactly one of rf_wr_en / rf_rd_en, WAIT
// (reads only) captures the registered read data, DONE pulses the winner's ack.
// Every output is a register. Build option REGFILE_ARB_FIXED_PRIO_EN selects
// fixed master-0 priority inside rr_arbiter2 instead of round-robin.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   req/we/addr/wdata0  master 0 request, 1=write, address, write data
//   req/we/addr/wdata1  master 1 request, 1=write, address, write data
//   ack0/ack1           one-cycle completion pulse to the granted master
//   rdata0/rdata1       last read result per master, held between reads
//   rf_wr_en/rf_rd_en   register-file enables, one cycle per transaction
//   rf_addr/rf_wr_data  register-file address and write data
//   rf_rd_data          register-file read data, valid the cycle after rf_rd_en
// -----------------------------------------------------------------------------
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    input  logic [DATA_W-1:0] rf_rd_data
);

    state_t            state, state_nxt;
    gnt_t              gnt, gnt_nxt;
    logic              lat_we, lat_we_nxt;
    logic              ack0_nxt, ack1_nxt;
    logic [DATA_W-1:0] rdata0_nxt, rdata1_nxt;
    logic              rf_wr_en_nxt, rf_rd_en_nxt;
    logic [ADDR_W-1:0] rf_addr_nxt;
    logic [DATA_W-1:0] rf_wr_data_nxt;

    logic              arb_valid;
    gnt_t              arb_idx;
    logic              arb_advance;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Requests are only looked at in IDLE, so a request held through a foreign
    // transaction is simply seen again at the next IDLE.
    assign arb_advance = (state == IDLE) && arb_valid;

    rr_arbiter2 u_arb (
        .CLK       (CLK),
        .RST       (RST),
        .req0      (req0),
        .req1      (req1),
        .advance   (arb_advance),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    assign sel_we    = arb_idx ? we1    : we0;
    assign sel_addr  = arb_idx ? addr1  : addr0;
    assign sel_wdata = arb_idx ? wdata1 : wdata0;

    // rf_addr / rf_wr_data double as the latched payload: they are loaded on
    // acceptance and held, so later payload changes by the master are ignored.
    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        lat_we_nxt     = lat_we;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        rdata0_nxt     = rdata0;
        rdata1_nxt     = rdata1;
        rf_wr_en_nxt   = 1'b0;
        rf_rd_en_nxt   = 1'b0;
        rf_addr_nxt    = rf_addr;
        rf_wr_data_nxt = rf_wr_data;

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt      = ISSUE;
                    gnt_nxt        = arb_idx;
                    lat_we_nxt     = sel_we;
                    rf_addr_nxt    = sel_addr;
                    rf_wr_data_nxt = sel_wdata;
                    // Enables are registered, so they are set on entry to
                    // ISSUE and are high for exactly that one cycle.
                    rf_wr_en_nxt   = sel_we;
                    rf_rd_en_nxt   = ~sel_we;
                end
            end
            ISSUE: begin
                if (lat_we) begin
                    state_nxt = DONE;
                    ack0_nxt  = (gnt == 1'b0);
                    ack1_nxt  = (gnt == 1'b1);
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // rf_rd_data is valid in this cycle; it lands in the winner's
                // rdata together with the ack, the other master's is untouched.
                state_nxt = DONE;
                if (gnt) begin
                    rdata1_nxt = rf_rd_data;
                    ack1_nxt   = 1'b1;
                end else begin
                    rdata0_nxt = rf_rd_data;
                    ack0_nxt   = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            lat_we     <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            rf_addr    <= '0;
            rf_wr_data <= '0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            lat_we     <= lat_we_nxt;
            ack0       <= ack0_nxt;
            ack1       <= ack1_nxt;
            rdata0     <= rdata0_nxt;
            rdata1     <= rdata1_nxt;
            rf_wr_en   <= rf_wr_en_nxt;
            rf_rd_en   <= rf_rd_en_nxt;
            rf_addr    <= rf_addr_nxt;
            rf_wr_data <= rf_wr_data_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
// Bench for regfile_arbiter. A transaction-level model decides the service
// order from the arbitration rules and tracks register-file contents; expected
// acks are queued at issue time and a negedge monitor pops and compares them
// whenever an ack appears. The register file itself is modelled behaviourally.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int ACK_BUDGET = 60;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          rf_wr_en, rf_rd_en;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wr_data;
    logic [DW-1:0] rf_rd_data = '0;

    logic [DW-1:0] rf_mem [8] = '{default: '0};

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    regfile_arbiter dut (
        .CLK        (CLK),
        .RST        (RST),
        .req0       (req0),
        .we0        (we0),
        .addr0      (addr0),
        .wdata0     (wdata0),
        .req1       (req1),
        .we1        (we1),
        .addr1      (addr1),
        .wdata1     (wdata1),
        .ack0       (ack0),
        .ack1       (ack1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .rf_wr_en   (rf_wr_en),
        .rf_rd_en   (rf_rd_en),
        .rf_addr    (rf_addr),
        .rf_wr_data (rf_wr_data),
        .rf_rd_data (rf_rd_data)
    );

    // Register file: keeps its own contents across arbiter reset, read data
    // registered one cycle after rf_rd_en.
    always @(posedge CLK) begin
        if (rf_wr_en) rf_mem[rf_addr] <= rf_wr_data;
        if (rf_rd_en) rf_rd_data <= rf_mem[rf_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        bit          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   order_q[$];

    logic [DW-1:0] mdl_mem [8];
    bit            mdl_ptr;

    bit            t_we   [2][8];
    logic [AW-1:0] t_addr [2][8];
    logic [DW-1:0] t_data [2][8];

    // Service order from the rules: each master's list is served in order;
    // a tie goes to the priority master, a lone requester always wins, and the
    // priority then passes to the master that was not granted.
    task automatic plan_burst(input int n0, input int n1);
        int idx [2];
        int n   [2];
        int w;
        bit both;
        exp_t e;
        idx[0] = 0; idx[1] = 0;
        n[0] = n0;  n[1] = n1;
        while (idx[0] < n[0] || idx[1] < n[1]) begin
            both = (idx[0] < n[0]) && (idx[1] < n[1]);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            w = both ? 0 : ((idx[0] < n[0]) ? 0 : 1);
`else
            w = both ? int'(mdl_ptr) : ((idx[0] < n[0]) ? 0 : 1);
            mdl_ptr = (w == 0);
`endif
            e.we   = t_we[w][idx[w]];
            e.addr = t_addr[w][idx[w]];
            if (e.we) begin
                e.data = t_data[w][idx[w]];
                mdl_mem[e.addr] = e.data;
            end else begin
                e.data = mdl_mem[e.addr];
            end
            if (w == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            order_q.push_back(w);
            idx[w]++;
        end
    endtask

    // ---------------- monitor ----------------
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    logic [AW-1:0] pulse_addr;
    logic [DW-1:0] pulse_data;
    logic [DW-1:0] prev_rd0, prev_rd1;
    bit            rst_prev = 1'b1;
    int            mon_m;
    int            mon_w;
    exp_t          mon_e;
    bit            mon_have;

    always @(negedge CLK) begin
        if (RST) begin
            wr_cnt   = 0;
            rd_cnt   = 0;
            rst_prev = 1'b1;
        end else begin
            if (rf_wr_en || rf_rd_en) begin
                check("rf_en_exclusive", {63'd0, rf_wr_en & rf_rd_en}, 64'd0);
                pulse_addr = rf_addr;
                if (rf_wr_en) begin
                    wr_cnt++;
                    pulse_data = rf_wr_data;
                end
                if (rf_rd_en) rd_cnt++;
            end
            if (!rst_prev) begin
                if (!ack0) check("rdata0_hold", rdata0, prev_rd0);
                if (!ack1) check("rdata1_hold", rdata1, prev_rd1);
            end
            if (ack0 || ack1) begin
                check("ack_onehot", {63'd0, ack0 & ack1}, 64'd0);
                mon_m = ack1 ? 1 : 0;
                if (order_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_expected: ack%0d seen with no transaction outstanding (t=%0t)", mon_m, $time);
                end else begin
                    mon_w = order_q.pop_front();
                    check("grant_order", mon_m, mon_w);
                    mon_have = 1'b0;
                    if (mon_m == 0 && exp_q0.size() > 0) begin
                        mon_e = exp_q0.pop_front(); mon_have = 1'b1;
                    end else if (mon_m == 1 && exp_q1.size() > 0) begin
                        mon_e = exp_q1.pop_front(); mon_have = 1'b1;
                    end
                    if (mon_have) begin
                        check("rf_pulse_count", {wr_cnt[15:0], rd_cnt[15:0]},
                              mon_e.we ? 64'h0001_0000 : 64'h0000_0001);
                        check("rf_addr", pulse_addr, mon_e.addr);
                        if (mon_e.we)
                            check("rf_wr_data", pulse_data, mon_e.data);
                        else
                            check(mon_m ? "rdata1" : "rdata0", mon_m ? rdata1 : rdata0, mon_e.data);
                    end
                end
                wr_cnt = 0;
                rd_cnt = 0;
            end
            rst_prev = 1'b0;
        end
        prev_rd0 = rdata0;
        prev_rd1 = rdata1;
    end

    // ---------------- drivers ----------------
    task automatic set_req(input int m, input bit r, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        if (m == 0) begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    // Presents the master's list back to back: a new transaction is put up in
    // the ack cycle, so a continuously requesting master never leaves a gap.
    task automatic drive_master(input int m, input int n);
        int cyc;
        bit got;
        for (int i = 0; i < n; i++) begin
            cyc = 0;
            set_req(m, 1'b1, t_we[m][i], t_addr[m][i], t_data[m][i]);
            do begin
                @(negedge CLK);
                cyc++;
                got = (m == 1) ? ack1 : ack0;
            end while (!got && cyc < ACK_BUDGET);
            check("ack_within_budget", {63'd0, got}, 64'd1);
        end
        set_req(m, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic gen_txns(input int m, input int n);
        for (int i = 0; i < n; i++) begin
            t_we[m][i]   = 1'($urandom_range(0, 1));
            t_addr[m][i] = AW'($urandom_range(0, 7));
            t_data[m][i] = DW'($urandom);
        end
    endtask

    task automatic run_burst(input int n0, input int n1);
        plan_burst(n0, n1);
        @(negedge CLK);
        fork
            drive_master(0, n0);
            drive_master(1, n1);
        join
        repeat (2) @(negedge CLK);
    endtask

    // Lone transaction with acceptance-to-ack latency measured in cycles.
    task automatic timed_txn(input int m, input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int exp_lat);
        int lat;
        t_we[m][0] = we; t_addr[m][0] = a; t_data[m][0] = d;
        if (m == 0) plan_burst(1, 0); else plan_burst(0, 1);
        @(negedge CLK);
        set_req(m, 1'b1, we, a, d);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!((m == 1) ? ack1 : ack0) && lat < ACK_BUDGET);
        check(we ? "write_ack_latency" : "read_ack_latency", lat, exp_lat);
        set_req(m, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        mdl_ptr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        for (int i = 0; i < 8; i++) mdl_mem[i] = '0;
        mdl_ptr = 1'b0;
        RST = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_outputs", {ack0, ack1, rdata0, rdata1, rf_wr_en, rf_rd_en, rf_addr, rf_wr_data}, 64'd0);
        RST = 1'b0;

        // Idle after reset: everything stays at zero.
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("idle_outputs", {ack0, ack1, rdata0, rdata1, rf_wr_en, rf_rd_en, rf_addr, rf_wr_data}, 64'd0);
        end

        // Master 0 write then read of address 3.
        timed_txn(0, 1'b1, 3'd3, 16'hA5A5, 2);
        timed_txn(0, 1'b0, 3'd3, 16'h0000, 3);
        check("rdata0_after_read", rdata0, 16'hA5A5);

        // Simultaneous request from a fresh pointer: master 0 write, master 1 read.
        pulse_reset();
        t_we[0][0] = 1'b1; t_addr[0][0] = 3'd1; t_data[0][0] = 16'h1111;
        t_we[1][0] = 1'b0; t_addr[1][0] = 3'd1; t_data[1][0] = 16'h0000;
        run_burst(1, 1);
        check("rdata1_after_tie", rdata1, 16'h1111);

        // After a lone master-0 grant the next tie goes to master 1.
        gen_txns(0, 1);
        run_burst(1, 0);
        t_we[0][0] = 1'b1; t_addr[0][0] = 3'd5; t_data[0][0] = 16'h2222;
        t_we[1][0] = 1'b0; t_addr[1][0] = 3'd5; t_data[1][0] = 16'h0000;
        run_burst(1, 1);

        // Both masters hold req for 8 transactions in total.
        gen_txns(0, 4);
        gen_txns(1, 4);
        run_burst(4, 4);

        // Random mixes of lone and competing requests.
        for (int r = 0; r < 25; r++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 == 0 && n1 == 0) n0 = 1;
            gen_txns(0, n0);
            gen_txns(1, n1);
            run_burst(n0, n1);
        end

        // Reset during WAIT of a master-0 read, with the pointer at master 1.
        t_we[0][0] = 1'b1; t_addr[0][0] = 3'd6; t_data[0][0] = 16'hBEEF;
        run_burst(1, 0);
        @(negedge CLK);
        set_req(0, 1'b1, 1'b0, 3'd6, '0);
        @(negedge CLK);                 // ISSUE
        @(negedge CLK);                 // WAIT
        RST = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        RST = 1'b0;
        mdl_ptr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("post_reset_ack0", {63'd0, ack0}, 64'd0);
            check("post_reset_rdata0", rdata0, 16'h0000);
            @(negedge CLK);
        end
        gen_txns(0, 1);
        gen_txns(1, 1);
        run_burst(1, 1);

        check("scoreboard_drained", order_q.size() + exp_q0.size() + exp_q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
